// File: rtl/ireg_feed_ctrl.sv
// Sequencer for the systolic array's input-register chain: clears rows, issues
// row-skewed enables and buffer read addresses, then drains with zero-filled shifts.
module ireg_feed_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [KW-1:0]   k_len,
  input  logic            stall,
  output logic [ROWS-1:0] row_en,
  output logic [ROWS-1:0] row_clr,
  output logic [KW-1:0]   rd_addr,
  output logic            rd_valid,
  output logic            zero_fill,
  output logic            busy,
  output logic            done
);

  localparam int CW = KW + $clog2(ROWS + COLS) + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] t;
  logic [KW-1:0] k_reg;
  logic [CW-1:0] k_ext;
  logic [CW-1:0] run_last;
  logic [CW-1:0] drain_last;

  assign k_ext      = CW'(k_reg);
  assign run_last   = k_ext + CW'(ROWS - 2);
  assign drain_last = k_ext + CW'(ROWS + COLS - 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      t     <= '0;
      k_reg <= '0;
    end else if (abort) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      case (state)
        IDLE: begin
          t <= '0;
          if (start) begin
            state <= CLEAR;
            k_reg <= k_len;
          end
        end
        CLEAR: begin
          t     <= '0;
          state <= (k_reg != '0) ? RUN : DONE;
        end
        RUN: begin
          if (!stall) begin
            t <= t + 1'b1;
            if (t == run_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!stall) begin
            t <= t + 1'b1;
            if (t == drain_last) state <= DONE;
          end
        end
        DONE: begin
          t     <= '0;
          state <= IDLE;
        end
        default: begin
          t     <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registered schedule; only stall and abort act within the cycle.
  always_comb begin
    row_en    = '0;
    row_clr   = '0;
    rd_addr   = '0;
    rd_valid  = 1'b0;
    zero_fill = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      CLEAR: begin
        row_clr = '1;
        busy    = 1'b1;
      end
      RUN: begin
        busy    = 1'b1;
        rd_addr = t[KW-1:0];
        rd_valid = (t < k_ext) && !stall;
        for (int unsigned r = 0; r < ROWS; r++) begin
          row_en[r] = (t >= CW'(r)) && (t < CW'(r) + k_ext) && !stall;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        zero_fill = 1'b1;
        row_en    = {ROWS{!stall}};
      end
      DONE: done = 1'b1;
      default: ;
    endcase
    if (abort) begin
      row_clr   = '1;
      row_en    = '0;
      rd_valid  = 1'b0;
      zero_fill = 1'b0;
      done      = 1'b0;
    end
  end

endmodule
